// File: rtl/simon_btn_conditioner.sv
// simon_btn_conditioner
//   Input stage for the Simon-says game FSM. Each of the four raw push-buttons is
//   synchronised (2-FF) and debounced. A clean single-button press-and-release becomes
//   one btn_valid strobe carrying the button's colour code. Multi-button presses and
//   presses made while input is disabled are rejected.
//
// Ports
//   Clk        in      system clock
//   Reset      in      asynchronous active-low reset
//   Enable     in      high while the game accepts user input
//   Btn_U/R/D/L in     raw, bouncing buttons (codes 1/2/3/4)
//   btn_code   out [3] code of the last accepted press, held until the next one
//   btn_valid  out     one-cycle strobe, btn_code holds a new completed press
//   btn_held   out     registered OR of the debounced button levels
//   multi_err  out     one-cycle strobe, a second button debounced during a press
module simon_btn_conditioner #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Btn_U,
  input  logic       Btn_R,
  input  logic       Btn_D,
  input  logic       Btn_L,
  output logic [2:0] btn_code,
  output logic       btn_valid,
  output logic       btn_held,
  output logic       multi_err
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLock} state_e;

  // Bit order everywhere: [0]=U, [1]=R, [2]=D, [3]=L.
  logic [3:0] raw_btn;
  assign raw_btn = {Btn_L, Btn_D, Btn_R, Btn_U};

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;         // code of the press in progress
  logic [2:0] btn_code_q, btn_code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       held_q, held_d;

  logic [2:0] n_down;
  logic [2:0] single_code;

  // Debounce: count consecutive cycles where the synchronised level disagrees with the
  // debounced level; any agreement clears the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    n_down = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n_down = n_down + {2'b00, db_q[i]};
    end
  end

  // Only meaningful when exactly one button is down.
  always_comb begin
    case (db_q)
      4'b0001: single_code = 3'd1;
      4'b0010: single_code = 3'd2;
      4'b0100: single_code = 3'd3;
      4'b1000: single_code = 3'd4;
      default: single_code = 3'd0;
    endcase
  end

  // Press tracking. In HELD, multi-press beats disable, which beats release.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    btn_code_d = btn_code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    held_d     = |db_q;
    case (state_q)
      StIdle: begin
        if (n_down != 3'd0) begin
          if (!Enable) begin
            state_d = StLock;
          end else if (n_down == 3'd1) begin
            code_d  = single_code;
            state_d = StHeld;
          end else begin
            err_d   = 1'b1;
            state_d = StLock;
          end
        end
      end
      StHeld: begin
        if (n_down >= 3'd2) begin
          err_d   = 1'b1;
          state_d = StLock;
        end else if (!Enable) begin
          state_d = StLock;
        end else if (n_down == 3'd0) begin
          btn_code_d = code_q;
          valid_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      StLock: begin
        if (n_down == 3'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      state_q    <= StIdle;
      code_q     <= '0;
      btn_code_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= raw_btn;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q    <= state_d;
      code_q     <= code_d;
      btn_code_q <= btn_code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      held_q     <= held_d;
    end
  end

  assign btn_code  = btn_code_q;
  assign btn_valid = valid_q;
  assign btn_held  = held_q;
  assign multi_err = err_q;

endmodule

// File: tb/tb_simon_btn_conditioner.sv
// Bench for simon_btn_conditioner with DB_CYCLES=4. Every cycle is compared against a
// reference model; table rows and hand-written sequences add targeted checks.
module tb_simon_btn_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] btns;  // [0]=U [1]=R [2]=D [3]=L
  logic [2:0] btn_code;
  logic       btn_valid;
  logic       btn_held;
  logic       multi_err;

  simon_btn_conditioner #(
    .DB_CYCLES(DB),
    .CNT_W    (CW)
  ) dut (
    .Clk      (clk),
    .Reset    (reset),
    .Enable   (enable),
    .Btn_U    (btns[0]),
    .Btn_R    (btns[1]),
    .Btn_D    (btns[2]),
    .Btn_L    (btns[3]),
    .btn_code (btn_code),
    .btn_valid(btn_valid),
    .btn_held (btn_held),
    .multi_err(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [3:0]    m_db;
  logic [DB+1:0] m_hist [4];  // m_hist[b][j] = raw level sampled j edges ago
  logic [2:0]    m_cand;      // press in progress (0 = none)
  bit            m_blocked;   // waiting for all buttons up
  logic [2:0]    m_code;
  logic          m_valid, m_err, m_held;

  int errors = 0;
  int checks = 0;
  int seg_valid, seg_err;
  bit seg_held_seen;

  typedef struct {
    logic       en;
    logic [3:0] b;
    int         cycles;
    int         exp_valid;
    int         exp_err;
    int         exp_code;
  } row_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  function automatic int popcnt(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_db = '0;
    for (int b = 0; b < 4; b++) m_hist[b] = '0;
    m_cand = '0;
    m_blocked = 0;
    m_code = '0;
    m_valid = 0;
    m_err = 0;
    m_held = 0;
  endtask

  // One clock edge of the model: outputs from the debounced levels before the edge, then
  // a level flips once its DB most recent synchronised samples all disagree with it.
  task automatic model_edge(input logic [3:0] r, input logic en, input logic rs);
    int n;
    logic [2:0] one;
    bit all_diff;
    if (!rs) begin
      model_reset();
      return;
    end
    n = popcnt(m_db);
    one = '0;
    for (int b = 0; b < 4; b++) if (m_db[b]) one = 3'(b + 1);
    m_held = (n != 0);
    m_valid = 0;
    m_err = 0;
    if (m_blocked) begin
      if (n == 0) m_blocked = 0;
    end else if (m_cand != 0) begin
      if (n >= 2) begin
        m_err = 1; m_blocked = 1; m_cand = '0;
      end else if (!en) begin
        m_blocked = 1; m_cand = '0;
      end else if (n == 0) begin
        m_code = m_cand; m_valid = 1; m_cand = '0;
      end
    end else if (n != 0) begin
      if (!en) m_blocked = 1;
      else if (n == 1) m_cand = one;
      else begin
        m_err = 1; m_blocked = 1;
      end
    end
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = {m_hist[b][DB:0], r[b]};
      all_diff = 1;
      for (int j = 2; j <= DB + 1; j++) if (m_hist[b][j] == m_db[b]) all_diff = 0;
      if (all_diff) m_db[b] = ~m_db[b];
    end
  endtask

  task automatic step();
    logic [3:0] r;
    logic en, rs;
    r = btns;
    en = enable;
    rs = reset;
    @(posedge clk);
    #1;
    model_edge(r, en, rs);
    check("cycle_outputs", int'({btn_code, btn_valid, btn_held, multi_err}),
          int'({m_code, m_valid, m_held, m_err}));
    if (btn_valid) seg_valid++;
    if (multi_err) seg_err++;
    if (btn_held) seg_held_seen = 1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic seg_clear();
    seg_valid = 0;
    seg_err = 0;
    seg_held_seen = 0;
  endtask

  row_t rows[$];
  int   first;
  int   hi, lo, c;

  initial begin
    // {en, buttons, cycles, valid strobes, err strobes, btn_code at end}
    rows.push_back('{1'b1, 4'b0010, 20, 0, 0, 1});  // R press
    rows.push_back('{1'b1, 4'b0000, 12, 1, 0, 2});
    rows.push_back('{1'b1, 4'b1000, 10, 0, 0, 2});  // L held, then U joins
    rows.push_back('{1'b1, 4'b1001, 10, 0, 1, 2});
    rows.push_back('{1'b1, 4'b0000, 12, 0, 0, 2});
    rows.push_back('{1'b1, 4'b1000, 20, 0, 0, 2});  // clean L
    rows.push_back('{1'b1, 4'b0000, 12, 1, 0, 4});
    rows.push_back('{1'b0, 4'b0001, 10, 0, 0, 4});  // disabled press
    rows.push_back('{1'b0, 4'b0000, 12, 0, 0, 4});
    rows.push_back('{1'b0, 4'b0001, 10, 0, 0, 4});  // enable rises while held
    rows.push_back('{1'b1, 4'b0001, 5, 0, 0, 4});
    rows.push_back('{1'b1, 4'b0000, 12, 0, 0, 4});
    rows.push_back('{1'b1, 4'b0100, 10, 0, 0, 4});  // disable during HELD
    rows.push_back('{1'b0, 4'b0100, 3, 0, 0, 4});
    rows.push_back('{1'b1, 4'b0000, 12, 0, 0, 4});
    rows.push_back('{1'b1, 4'b0011, 10, 0, 1, 4});  // same-cycle double press
    rows.push_back('{1'b1, 4'b0000, 12, 0, 0, 4});
    rows.push_back('{1'b1, 4'b0100, 10, 0, 0, 4});
    rows.push_back('{1'b1, 4'b0000, 12, 1, 0, 3});
    rows.push_back('{1'b1, 4'b0010, 10, 0, 0, 3});  // multi beats disable
    rows.push_back('{1'b1, 4'b1010, 6, 0, 0, 3});
    rows.push_back('{1'b0, 4'b1010, 5, 0, 1, 3});
    rows.push_back('{1'b1, 4'b0000, 12, 0, 0, 3});
    rows.push_back('{1'b1, 4'b0001, 10, 0, 0, 3});  // disable beats release
    rows.push_back('{1'b0, 4'b0000, 12, 0, 0, 3});

    model_reset();
    reset = 1'b0;
    enable = 1'b1;
    btns = 4'b0000;

    // Reset held: buttons wiggle, outputs stay quiet.
    seg_clear();
    for (int i = 0; i < 10; i++) begin
      btns = 4'($urandom);
      step();
    end
    check("reset_quiet", seg_valid + seg_err + int'(seg_held_seen) + int'(btn_code), 0);

    // Release reset with D already held.
    btns = 4'b0100;
    reset = 1'b1;
    run(10);
    check("held_after_reset", int'(btn_held), 1);
    btns = 4'b0000;
    seg_clear();
    run(12);
    check("reset_press_valid", seg_valid, 1);
    check("reset_press_code", int'(btn_code), 3);

    // Latency of held and valid relative to raw edges.
    btns = 4'b0001;
    seg_clear();
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (btn_held && first == 0) first = i;
    end
    check("held_latency", first, 7);
    btns = 4'b0000;
    seg_clear();
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (btn_valid && first == 0) first = i;
    end
    check("valid_latency", first, 7);
    check("u_valid_count", seg_valid, 1);
    check("u_code", int'(btn_code), 1);

    // Bouncing R: pulses never long enough to be accepted.
    seg_clear();
    c = 0;
    while (c < 30) begin
      hi = int'($urandom_range(1, 3));
      lo = int'($urandom_range(1, 3));
      btns = 4'b0010;
      run(hi);
      btns = 4'b0000;
      run(lo);
      c += hi + lo;
    end
    run(10);
    check("bounce_valid", seg_valid, 0);
    check("bounce_held", int'(seg_held_seen), 0);

    foreach (rows[k]) begin
      enable = rows[k].en;
      btns = rows[k].b;
      seg_clear();
      run(rows[k].cycles);
      check($sformatf("row%0d_valid", k), seg_valid, rows[k].exp_valid);
      check($sformatf("row%0d_err", k), seg_err, rows[k].exp_err);
      check($sformatf("row%0d_code", k), int'(btn_code), rows[k].exp_code);
    end

    // Reset mid-press discards the press.
    enable = 1'b1;
    btns = 4'b0100;
    run(10);
    reset = 1'b0;
    btns = 4'b0000;
    seg_clear();
    run(3);
    reset = 1'b1;
    run(12);
    check("midreset_valid", seg_valid, 0);
    check("midreset_code", int'(btn_code), 0);
    btns = 4'b0010;
    run(10);
    btns = 4'b0000;
    seg_clear();
    run(12);
    check("post_reset_valid", seg_valid, 1);
    check("post_reset_code", int'(btn_code), 2);

    // Random traffic against the model.
    seg_clear();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btns[$urandom_range(0, 3)] = ~btns[$urandom_range(0, 3)];
      if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 399) != 0);
      step();
      check("strobe_exclusive", int'(btn_valid & multi_err), 0);
    end
    reset = 1'b1;
    btns = 4'b0000;
    run(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
